moka_rv32i_trace_buffer: RTL

Parametrised execution-trace capture buffer for the moka RV32I core. Each cycle it samples the core's internal retire signals (pc, instruction, rd, WD3, RegWrite, MemWrite) into a DEPTH-entry circular store. Capture can be started by a PC trigger and run in stop-on-full or wrap mode. Records are drained through a valid/ready read port for bench scoreboards or a debug bridge.

---
 rtl/moka_rv32i_trace_buffer_if.sv | 37 +++
 rtl/moka_rv32i_trace_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/moka_rv32i_trace_buffer_if.sv
// Read-side interface of the moka RV32I trace buffer.
//
// Carries the first-word-fall-through drain port.
//   master : the trace buffer. It drives rd_valid and the oldest-record fields
//            rd_pc, rd_instr, rd_wdata, rd_rd and rd_flags, and it samples rd_ready.
//   slave  : the consumer (scoreboard or debug bridge). It drives rd_ready.
interface moka_rv32i_trace_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_pc;
  logic [DATA_WIDTH-1:0] rd_instr;
  logic [DATA_WIDTH-1:0] rd_wdata;
  logic [4:0]            rd_rd;
  logic [1:0]            rd_flags;

  modport master (
    output rd_valid,
    output rd_pc,
    output rd_instr,
    output rd_wdata,
    output rd_rd,
    output rd_flags,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_pc,
    input  rd_instr,
    input  rd_wdata,
    input  rd_rd,
    input  rd_flags,
    output rd_ready
  );
endinterface

// File: rtl/moka_rv32i_trace_buffer.sv
// moka_rv32i_trace_buffer: an execution-trace capture buffer for the moka RV32I core.
//
// The buffer samples the retire signals (pc, instruction, rd, WD3, RegWrite and
// MemWrite) into a circular store of DEPTH entries. A PC trigger can start the
// capture. The buffer runs in stop-on-full mode or in wrap mode. The read port
// is first-word-fall-through.
//
// Ports:
//   clk, rst_n        core clock. Asynchronous active-low reset.
//   en                capture enable. When en is low, the FSM goes to IDLE and the contents are kept.
//   clr               synchronous flush of count, pointers and overflow. The FSM state does not change.
//   mode              0 = stop-on-full, 1 = wrap (overwrite the oldest record).
//   trig_en, trig_pc  when trig_en is set, the buffer waits in ARMED until pc == trig_pc.
//   pc, instruction, rd, WD3, RegWrite, MemWrite   the retire signals to record.
//   rd_if (master)    drain port: rd_valid/rd_ready and the oldest record's fields.
//   count             number of records held, 0..DEPTH.
//   overflow          sticky. Set when wrap mode overwrites a record.
//   state             00 IDLE, 01 ARMED, 10 CAPTURE, 11 FROZEN.
//
// Build option:
//   MOKA_TRACE_FILTER_EN  when this macro is defined, a capture cycle pushes a record only if
//                         RegWrite or MemWrite is set. The trigger still fires on a pc match.
module moka_rv32i_trace_buffer #(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  localparam int         CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  mode,
  input  logic                  trig_en,
  input  logic [DATA_WIDTH-1:0] trig_pc,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic [4:0]            rd,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  RegWrite,
  input  logic                  MemWrite,
  moka_rv32i_trace_buffer_if.master rd_if,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic [1:0]            state
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_FROZEN  = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  overflow_q;

  logic [DATA_WIDTH-1:0] mem_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] mem_instr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_wdata [DEPTH];
  logic [4:0]            mem_rd    [DEPTH];
  logic [1:0]            mem_flags [DEPTH];

  logic full, almost_full, rd_valid_w;
  logic pop, push, drop, capture_cycle, strobe_ok;

`ifdef MOKA_TRACE_FILTER_EN
  assign strobe_ok = RegWrite | MemWrite;
`else
  assign strobe_ok = 1'b1;
`endif

  assign full        = (count_q == CNT_W'(DEPTH));
  assign almost_full = (count_q == CNT_W'(DEPTH - 1));
  assign rd_valid_w  = (count_q != '0);
  // clr overrides both sides of the store in the same cycle.
  assign pop         = rd_valid_w & rd_if.rd_ready & ~clr;
  // A push into a full store without a pop can only happen in wrap mode.
  // In that case the oldest record is discarded.
  assign drop        = push & full & ~pop;

  always_comb begin
    state_d       = state_q;
    capture_cycle = 1'b0;
    push          = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = trig_en ? S_ARMED : S_CAPTURE;
        S_ARMED: begin
          if (pc == trig_pc) begin
            state_d       = S_CAPTURE;
            capture_cycle = 1'b1;
          end
        end
        S_CAPTURE: capture_cycle = 1'b1;
        S_FROZEN:  state_d = S_FROZEN;
        default:   state_d = S_IDLE;
      endcase
    end

    // The trigger cycle follows the same full/stop rules as a normal capture cycle.
    // When clr is set, it cancels the push. It also cancels any freeze that depends on fill level.
    if (capture_cycle && !clr) begin
      if (!mode && full && !pop) begin
        state_d = S_FROZEN;
      end else begin
        push = strobe_ok;
        if (push && !mode && !pop && almost_full) begin
          state_d = S_FROZEN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
        mem_wdata[i] <= '0;
        mem_rd[i]    <= '0;
        mem_flags[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (clr) begin
        count_q    <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) begin
          mem_pc[wr_ptr]    <= pc;
          mem_instr[wr_ptr] <= instruction;
          mem_wdata[wr_ptr] <= WD3;
          mem_rd[wr_ptr]    <= rd;
          mem_flags[wr_ptr] <= {MemWrite, RegWrite};
          wr_ptr            <= wr_ptr + PTR_W'(1);
        end
        if (pop || drop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (drop) begin
          overflow_q <= 1'b1;
        end
        if (push && !pop && !full) begin
          count_q <= count_q + CNT_W'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  assign rd_if.rd_valid = rd_valid_w;
  assign rd_if.rd_pc    = mem_pc[rd_ptr];
  assign rd_if.rd_instr = mem_instr[rd_ptr];
  assign rd_if.rd_wdata = mem_wdata[rd_ptr];
  assign rd_if.rd_rd    = mem_rd[rd_ptr];
  assign rd_if.rd_flags = mem_flags[rd_ptr];

  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule
